// File: rtl/multi_pulser.sv
// Multi-channel synchronising edge-to-pulse converter with selectable edge type,
// fixed pulse length and either retrigger or sticky-overrun handling of early edges.
module multi_pulser #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int RETRIGGER   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   dataIn,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clearOverrun,
  output logic [CHANNELS-1:0]   dataOut,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   overrun
);

  localparam int              CW   = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0]   LOAD = CW'(PULSE_LEN);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  logic [CHANNELS-1:0]    sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] arm_q;
  logic                   armed;
  logic [CHANNELS-1:0]    prev_q;
  logic [CHANNELS-1:0]    s, rise, fall;
  logic [CHANNELS-1:0]    hit, active, ovr_set, ovr_q;
  logic [CW-1:0]          cnt_q [CHANNELS];
  logic [CW-1:0]          cnt_d [CHANNELS];

  assign armed = arm_q[SYNC_STAGES-1];
  assign s     = sync_q[SYNC_STAGES-1];
  assign rise  = s & ~prev_q;
  assign fall  = ~s & prev_q;

  // NOTE: the synchroniser array is a bank of flops, not RAM, so resetting every stage is intended.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      arm_q  <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= dataIn;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      arm_q <= {arm_q[SYNC_STAGES-2:0], 1'b1};
      // While arming, preload prev with the level s is about to take so a held input never looks like an edge.
      prev_q <= armed ? s : sync_q[SYNC_STAGES-2];
    end
  end

  // NOTE: every always_comb output gets a default before the loop so no latch can be inferred.
  always_comb begin
    hit     = '0;
    active  = '0;
    ovr_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      active[i] = (cnt_q[i] != '0);
      hit[i]    = armed & ((mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]));
      if (hit[i] && (!active[i] || RETRIGGER != 0)) begin
        cnt_d[i] = LOAD;
      end else if (active[i]) begin
        cnt_d[i]   = cnt_q[i] - ONE;
        ovr_set[i] = hit[i];
      end
    end
  end

  // Outputs are registered from the next-state count so they line up with the counter.
  // With RETRIGGER set, an edge on an active channel always reloads, so ovr_set and overrun stay 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      dataOut <= '0;
      busy    <= '0;
      ovr_q   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= cnt_d[i];
        dataOut[i] <= (cnt_d[i] != '0);
        busy[i]    <= (cnt_d[i] != '0);
      end
      ovr_q <= ovr_set | (ovr_q & ~clearOverrun);
    end
  end

  assign overrun = ovr_q;

endmodule

// File: tb/tb_multi_pulser.sv
// Directed bench for multi_pulser: four builds share one stimulus bus and each
// test checks the build whose parameters it exercises.
module tb_multi_pulser;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] data_in = '0;
  logic [3:0] clr = '0;
  logic [7:0] mode = '0;

  logic [3:0] out_def, busy_def, ovr_def;
  logic [3:0] out_p5,  busy_p5,  ovr_p5;
  logic [3:0] out_r5,  busy_r5,  ovr_r5;
  logic [3:0] out_p4,  busy_p4,  ovr_p4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  multi_pulser u_def (
    .clock(clock), .reset(reset), .dataIn(data_in), .mode(mode), .clearOverrun(clr),
    .dataOut(out_def), .busy(busy_def), .overrun(ovr_def));

  multi_pulser #(.PULSE_LEN(5), .RETRIGGER(0)) u_p5 (
    .clock(clock), .reset(reset), .dataIn(data_in), .mode(mode), .clearOverrun(clr),
    .dataOut(out_p5), .busy(busy_p5), .overrun(ovr_p5));

  multi_pulser #(.PULSE_LEN(5), .RETRIGGER(1)) u_r5 (
    .clock(clock), .reset(reset), .dataIn(data_in), .mode(mode), .clearOverrun(clr),
    .dataOut(out_r5), .busy(busy_r5), .overrun(ovr_r5));

  multi_pulser #(.PULSE_LEN(4)) u_p4 (
    .clock(clock), .reset(reset), .dataIn(data_in), .mode(mode), .clearOverrun(clr),
    .dataOut(out_p4), .busy(busy_p4), .overrun(ovr_p4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Pulse reset, release it, and wait long enough for arming to complete.
  task automatic restart();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(4);
  endtask

  logic [11:0] t3_out = 12'h07C;
  logic [11:0] t3_ovr = 12'hFF0;
  logic [11:0] t4_out = 12'h3FC;

  initial begin
    step(2);
    check("reset_out",  32'(out_def),  32'h0);
    check("reset_busy", 32'(busy_def), 32'h0);
    check("reset_ovr",  32'(ovr_def),  32'h0);

    // Test 1: single rise on ch0, pulse appears after E2 for one cycle.
    mode = 8'h55; data_in = 4'h0;
    restart();
    data_in = 4'h1;
    step(); check("t1_e0", 32'(out_def), 32'h0);
    step(); check("t1_e1", 32'(out_def), 32'h0);
    step(); check("t1_e2", 32'(out_def), 32'h1);
    check("t1_e2_busy", 32'(busy_def), 32'h1);
    step(); check("t1_e3", 32'(out_def), 32'h0);

    // Test 2: inputs held high through reset release give no pulse; the later fall hits all channels.
    reset = 1'b0; data_in = 4'hF; mode = 8'hFF;
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); check($sformatf("t2_hold%0d", i), 32'(out_def), 32'h0);
    end
    data_in = 4'h0;
    step(); step(); check("t2_e1", 32'(out_def), 32'h0);
    step(); check("t2_e2", 32'(out_def), 32'hF);
    step(); check("t2_e3", 32'(out_def), 32'h0);

    // Test 3: PULSE_LEN=5, no retrigger; rise/fall/rise two cycles apart on ch1.
    mode = 8'h0C; data_in = 4'h0;
    restart();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) data_in[1] = 1'b1;
      if (c == 2) data_in[1] = 1'b0;
      if (c == 4) data_in[1] = 1'b1;
      step();
      check($sformatf("t3_out_c%0d", c), 32'(out_p5), 32'({2'b00, t3_out[c], 1'b0}));
      check($sformatf("t3_ovr_c%0d", c), 32'(ovr_p5), 32'({2'b00, t3_ovr[c], 1'b0}));
    end
    check("t3_busy_idle", 32'(busy_p5), 32'h0);
    clr = 4'b0010;
    step();
    clr = 4'b0000;
    check("t3_ovr_cleared", 32'(ovr_p5), 32'h0);

    // Test 4: PULSE_LEN=5 with retrigger; fall 3 cycles after rise extends to 8 cycles.
    mode = 8'h0C; data_in = 4'h0;
    restart();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) data_in[1] = 1'b1;
      if (c == 3) data_in[1] = 1'b0;
      step();
      check($sformatf("t4_out_c%0d", c), 32'(out_r5), 32'({2'b00, t4_out[c], 1'b0}));
      check($sformatf("t4_busy_c%0d", c), 32'(busy_r5), 32'({2'b00, t4_out[c], 1'b0}));
      check($sformatf("t4_ovr_c%0d", c), 32'(ovr_r5), 32'h0);
    end

    // Test 5: mode 00 blocks pulses on ch2; switching to fall-only then dropping the input gives one pulse.
    mode = 8'h00; data_in = 4'h0;
    restart();
    for (int c = 0; c < 10; c++) begin
      data_in[2] = ((c / 2) % 2 == 0);
      step(); check($sformatf("t5_off_c%0d", c), 32'(out_def), 32'h0);
    end
    data_in[2] = 1'b1;
    step(3); check("t5_settled", 32'(out_def), 32'h0);
    mode = 8'h20;
    step(); check("t5_mode_sw", 32'(out_def), 32'h0);
    data_in[2] = 1'b0;
    step(); check("t5_e0", 32'(out_def), 32'h0);
    step(); check("t5_e1", 32'(out_def), 32'h0);
    step(); check("t5_e2", 32'(out_def), 32'h4);
    step(); check("t5_e3", 32'(out_def), 32'h0);

    // Test 6: PULSE_LEN=4; reset two cycles into the pulse drops it at once, nothing after release.
    mode = 8'h01; data_in = 4'h0;
    restart();
    data_in = 4'h1;
    step(3); check("t6_start", 32'(out_p4), 32'h1);
    step();  check("t6_mid",   32'(out_p4), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_out",  32'(out_p4),  32'h0);
    check("t6_async_busy", 32'(busy_p4), 32'h0);
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); check($sformatf("t6_after%0d", i), 32'(out_p4), 32'h0);
    end
    check("t6_ovr", 32'(ovr_p4), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
